// File: rtl/imem_loader.sv
// Byte-stream program loader for the multicycle core's instruction memory.
// Packs big-endian words after a 16-bit count header, then pulses start.
module imem_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        I_MEM_Write_Enable,
    output logic [31:0] I_MEM_Data_In,
    output logic [15:0] I_MEM_Write_Addr,
    output logic        start,
    output logic        load_done,
    output logic [15:0] words_written
);

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        WRITE,
        START,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept_st;
    logic        xfer;
    logic [7:0]  count_hi;
    logic [15:0] remaining;
    logic [1:0]  byte_idx;
    logic [31:0] word_buf;
    logic [15:0] addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HDR_HI;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept_st = 1'b0;
        unique case (state)
            HDR_HI: begin
                accept_st = 1'b1;
                if (in_valid) begin
                    state_nxt = HDR_LO;
                end
            end
            HDR_LO: begin
                accept_st = 1'b1;
                if (in_valid) begin
                    if ({count_hi, in_data} == 16'd0) begin
                        state_nxt = START;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                accept_st = 1'b1;
                if (in_valid && byte_idx == 2'd3) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (remaining == 16'd1) begin
                    state_nxt = START;
                end else begin
                    state_nxt = DATA;
                end
            end
            START: begin
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = HDR_HI;
            end
        endcase
    end

    // Gating with rst keeps a reset cycle from consuming, writing or starting.
    assign in_ready           = accept_st & ~rst;
    assign xfer               = in_valid & in_ready;
    assign I_MEM_Write_Enable = (state == WRITE) & ~rst;
    assign start              = (state == START) & ~rst;
    assign load_done          = (state == DONE) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_hi         <= 8'd0;
            remaining        <= 16'd0;
            byte_idx         <= 2'd0;
            word_buf         <= 32'd0;
            addr             <= BASE_ADDR;
            I_MEM_Data_In    <= 32'd0;
            I_MEM_Write_Addr <= 16'd0;
            words_written    <= 16'd0;
        end else begin
            unique case (state)
                HDR_HI: begin
                    if (xfer) begin
                        count_hi <= in_data;
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        remaining <= {count_hi, in_data};
                        byte_idx  <= 2'd0;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        // Left shift lands the first byte in [31:24].
                        word_buf <= {word_buf[23:0], in_data};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            I_MEM_Data_In    <= {word_buf[23:0], in_data};
                            I_MEM_Write_Addr <= addr;
                        end
                    end
                end
                WRITE: begin
                    addr          <= addr + 16'd1;
                    words_written <= words_written + 16'd1;
                    remaining     <= remaining - 16'd1;
                    byte_idx      <= 2'd0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream model.
// Two instances share the stream: base 0x0000 and base 0xFFFF (wrap).
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;

    logic        a_ready, a_we, a_start, a_done;
    logic [31:0] a_din;
    logic [15:0] a_addr, a_ww;
    logic        b_ready, b_we, b_start, b_done;
    logic [31:0] b_din;
    logic [15:0] b_addr, b_ww;

    imem_loader #(.BASE_ADDR(16'h0000)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_ready), .I_MEM_Write_Enable(a_we),
        .I_MEM_Data_In(a_din), .I_MEM_Write_Addr(a_addr),
        .start(a_start), .load_done(a_done), .words_written(a_ww)
    );

    imem_loader #(.BASE_ADDR(16'hFFFF)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_ready), .I_MEM_Write_Enable(b_we),
        .I_MEM_Data_In(b_din), .I_MEM_Write_Addr(b_addr),
        .start(b_start), .load_done(b_done), .words_written(b_ww)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
        int          c;
    } wr_t;

    wr_t         wa[$];
    wr_t         wb[$];
    logic [7:0]  acc[$];
    int          acc_cyc[$];
    int          starts_a = 0;
    int          starts_b = 0;
    int          start_cyc = 0;
    logic [31:0] words_q[$];

    int n_chk = 0;
    int n_err = 0;

    always @(negedge clk) begin
        if (a_we) wa.push_back(wr_t'{a_addr, a_din, cyc});
        if (b_we) wb.push_back(wr_t'{b_addr, b_din, cyc});
        if (a_start) begin
            starts_a++;
            start_cyc = cyc;
        end
        if (b_start) starts_b++;
        if (in_valid && a_ready) begin
            acc.push_back(in_data);
            acc_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        wa.delete();
        wb.delete();
        acc.delete();
        acc_cyc.delete();
        starts_a = 0;
        starts_b = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(a_ready), 0);
        chk("rst_we", 32'(a_we | b_we), 0);
        chk("rst_start", 32'(a_start | b_start), 0);
        chk("rst_done", 32'(a_done), 0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_din", a_din, 0);
        chk("rst_addr", 32'(a_addr), 0);
        chk("rst_ww", 32'(a_ww), 0);
        chk("rst_ww_b", 32'(b_ww), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(a_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap,
                             input bit after_word);
        bit ok;
        int guard;
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            @(negedge clk);
            if (!(i == 0 && after_word))
                chk("ready_in_gap", 32'(a_ready), 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data = b;
        ok = 1'b0;
        guard = 0;
        while (!ok && guard < 20) begin
            @(negedge clk);
            ok = a_ready;
            guard++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'(ok), 1);
    endtask

    task automatic run_load(input int n, input int gap_max,
                            input bit fixed_gap, input bit timing);
        logic [7:0]  bq[$];
        logic [15:0] eb;
        int g;
        int m;
        clear_obs();
        while (words_q.size() < n) words_q.push_back($urandom);
        bq.push_back(8'(n >> 8));
        bq.push_back(8'(n));
        for (int i = 0; i < n; i++)
            for (int k = 3; k >= 0; k--)
                bq.push_back(8'(words_q[i] >> (8 * k)));
        foreach (bq[k]) begin
            if (k == 0) g = 0;
            else if (fixed_gap) g = gap_max;
            else g = int'($urandom_range(0, gap_max));
            send_byte(bq[k], g, k >= 6 && (k - 2) % 4 == 0);
        end
        for (int w = 0; w < 30 && !a_done; w++) @(negedge clk);
        chk("load_done_a", 32'(a_done), 1);
        chk("load_done_b", 32'(b_done), 1);
        chk("n_writes_a", wa.size(), n);
        chk("n_writes_b", wb.size(), n);
        m = (wa.size() < n) ? wa.size() : n;
        for (int i = 0; i < m; i++) begin
            chk("wr_addr_a", 32'(wa[i].a), 32'(16'(i)));
            chk("wr_data_a", wa[i].d, words_q[i]);
            if (timing && i > 0)
                chk("strobe_gap", wa[i].c - wa[i-1].c, 5);
        end
        m = (wb.size() < n) ? wb.size() : n;
        for (int i = 0; i < m; i++) begin
            eb = 16'hFFFF + 16'(i);
            chk("wr_addr_b", 32'(wb[i].a), 32'(eb));
            chk("wr_data_b", wb[i].d, words_q[i]);
        end
        chk("starts_a", starts_a, 1);
        chk("starts_b", starts_b, 1);
        chk("n_accepted", acc.size(), bq.size());
        m = (acc.size() < bq.size()) ? acc.size() : bq.size();
        for (int i = 0; i < m; i++) chk("acc_byte", 32'(acc[i]), 32'(bq[i]));
        chk("words_written_a", 32'(a_ww), 32'(16'(n)));
        chk("words_written_b", 32'(b_ww), 32'(16'(n)));
        if (timing && acc_cyc.size() > 0)
            chk("start_latency", start_cyc - acc_cyc[0], 2 + 5 * n);
        words_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int gm;
        do_reset();

        words_q = '{32'h20010005, 32'h8C220003};
        run_load(2, 0, 1'b1, 1'b1);

        do_reset();
        run_load(0, 0, 1'b1, 1'b1);

        clear_obs();
        in_valid = 1'b1;
        in_data = 8'hA5;
        repeat (10) begin
            @(negedge clk);
            chk("done_ready", 32'(a_ready), 0);
            chk("done_start", 32'(a_start), 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("done_accepts", acc.size(), 0);
        chk("done_writes", wa.size(), 0);

        do_reset();
        words_q = '{32'hDEADBEEF};
        run_load(1, 3, 1'b1, 1'b0);

        do_reset();
        words_q = '{32'h11111111, 32'h22222222};
        run_load(2, 0, 1'b1, 1'b1);

        do_reset();
        clear_obs();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h03, 0, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(8'($urandom), 0, 1'b0);
        send_byte(8'h5A, 0, 1'b1);
        send_byte(8'hC3, 0, 1'b0);
        do_reset();
        chk("abort_writes", wa.size(), 1);
        chk("abort_start", starts_a, 0);
        words_q = '{32'h12345678};
        run_load(1, 0, 1'b1, 1'b1);

        do_reset();
        clear_obs();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(8'($urandom), 0, 1'b0);
        do_reset();
        chk("abort_in_write", wa.size(), 0);
        chk("abort_in_write_start", starts_a, 0);

        repeat (8) begin
            do_reset();
            n = int'($urandom_range(0, 6));
            gm = int'($urandom_range(0, 3));
            run_load(n, gm, 1'b0, gm == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
